// File: rtl/median_filter_sched_mc.sv
// Median filter line scheduler. Pops a shared multi-channel line stack,
// feeds an external fixed-latency core, and re-times the middle-line pixel
// and frame tags so border, bypass and core results leave together.
module median_filter_sched_mc #(
  parameter int SIZE  = 3,
  parameter int NCH   = 2,
  parameter int DW_VD = 14,
  parameter int DW_MD = 16,
  parameter int LAT   = 4
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [DW_MD-1:0]              cfg_iw,
  input  logic [DW_MD-1:0]              cfg_ih,
  input  logic                          cfg_bypass,
  input  logic                          cfg_border,
  input  logic                          frm_abort,
  input  logic [SIZE*NCH*(DW_VD+1)-1:0] line_stack_dout,
  output logic                          line_stack_rd_en,
  input  logic [15:0]                   rcvd_line_cntr,
  output logic [15:0]                   sent_line_cntr,
  output logic [SIZE*NCH*DW_VD-1:0]     core_din,
  input  logic [NCH*DW_VD-1:0]          core_dout,
  input  logic                          core_dout_val,
  output logic [NCH*DW_VD-1:0]          out_dat,
  output logic                          out_val,
  output logic                          out_sof,
  output logic                          out_eol,
  input  logic                          out_rdy,
  output logic                          err_sync
);

  localparam int HALF = SIZE / 2;
  localparam int PW   = NCH * DW_VD;
  localparam int EW   = DW_VD + 1;

  typedef enum logic [1:0] {S_WAIT, S_FILL, S_SEND, S_FEND} state_t;

  state_t           state, state_nx;
  logic [DW_MD-1:0] pix_cnt, pix_nx;
  logic [2:0]       fill_cnt, fill_nx;
  logic [15:0]      sent_nx;
  logic [DW_MD-1:0] iw_q, ih_q;
  logic             bypass_q, border_q;
  logic [15:0]      ih16;
  logic             free_to_send, last_pix, issue, border, tag_sof;

  logic [PW-1:0]       mid_pix;
  logic [NCH-1:0]      mid_mask;
  logic [SIZE*NCH-1:0] all_mask;
  logic                unused_mask;

  // Delay line entries, stage 0 captured at the issuing pop.
  logic          vld_p [LAT];
  logic          sof_p [LAT];
  logic          eol_p [LAT];
  logic          brd_p [LAT];
  logic [PW-1:0] pix_p [LAT];

  assign ih16     = 16'(ih_q);
  assign last_pix = (pix_cnt == iw_q - 1'b1);
  assign tag_sof  = (sent_line_cntr == 16'd0) && (pix_cnt == '0);

  // Once the frame is partly received, only send when a full kernel of lines
  // below the current line is already in the stack.
  assign free_to_send = (rcvd_line_cntr < ih16) ?
                        ((rcvd_line_cntr - sent_line_cntr) > 16'(HALF)) : 1'b1;

  // Only the middle-line masks matter; the others are folded away.
  assign unused_mask = ^all_mask;

  // Any masked channel on the middle line marks the whole position as border.
  assign border = (sent_line_cntr < 16'(HALF)) ||
                  (sent_line_cntr >= ih16 - 16'(HALF)) ||
                  (pix_cnt < DW_MD'(HALF)) ||
                  (pix_cnt >= iw_q - DW_MD'(HALF)) ||
                  !(&mid_mask);

  // Strip mask bits for the core and pick out the middle line.
  always_comb begin
    core_din = '0;
    mid_pix  = '0;
    mid_mask = '0;
    all_mask = '0;
    for (int l = 0; l < SIZE; l++) begin
      for (int c = 0; c < NCH; c++) begin
        core_din[(l*NCH+c)*DW_VD +: DW_VD] = line_stack_dout[(l*NCH+c)*EW +: DW_VD];
        all_mask[l*NCH+c]                  = line_stack_dout[(l*NCH+c)*EW + DW_VD];
      end
    end
    for (int c = 0; c < NCH; c++) begin
      mid_pix[c*DW_VD +: DW_VD] = line_stack_dout[(HALF*NCH+c)*EW +: DW_VD];
      mid_mask[c]               = line_stack_dout[(HALF*NCH+c)*EW + DW_VD];
    end
  end

  // Next-state, pop strobe and counter updates.
  always_comb begin
    state_nx         = state;
    line_stack_rd_en = 1'b0;
    issue            = 1'b0;
    pix_nx           = pix_cnt;
    fill_nx          = fill_cnt;
    sent_nx          = sent_line_cntr;
    case (state)
      S_WAIT: begin
        if ((fill_cnt < 3'(HALF)) && (rcvd_line_cntr > {13'd0, fill_cnt}) && out_rdy)
          state_nx = S_FILL;
        else if ((fill_cnt == 3'(HALF)) && out_rdy && free_to_send)
          state_nx = S_SEND;
      end
      S_FILL: begin
        line_stack_rd_en = 1'b1;
        if (last_pix) begin
          pix_nx   = '0;
          fill_nx  = fill_cnt + 3'd1;
          state_nx = S_WAIT;
        end else begin
          pix_nx = pix_cnt + 1'b1;
        end
      end
      S_SEND: begin
        line_stack_rd_en = out_rdy;
        issue            = out_rdy;
        if (out_rdy) begin
          if (last_pix) begin
            pix_nx   = '0;
            sent_nx  = sent_line_cntr + 16'd1;
            state_nx = (sent_line_cntr == ih16 - 16'd1) ? S_FEND : S_WAIT;
          end else begin
            pix_nx = pix_cnt + 1'b1;
          end
        end
      end
      S_FEND: begin
        if (rcvd_line_cntr == 16'd0) begin
          sent_nx  = '0;
          pix_nx   = '0;
          fill_nx  = '0;
          state_nx = S_WAIT;
        end
      end
      default: state_nx = S_WAIT;
    endcase
    if (frm_abort)
      state_nx = S_FEND;
  end

  // State and position counters.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= S_WAIT;
      pix_cnt        <= '0;
      fill_cnt       <= '0;
      sent_line_cntr <= '0;
    end else begin
      state          <= state_nx;
      pix_cnt        <= pix_nx;
      fill_cnt       <= fill_nx;
      sent_line_cntr <= sent_nx;
    end
  end

  // Frame configuration is captured only while idle between frames.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      iw_q     <= '0;
      ih_q     <= '0;
      bypass_q <= 1'b0;
      border_q <= 1'b0;
    end else if (state == S_WAIT && sent_line_cntr == 16'd0 && fill_cnt == 3'd0) begin
      iw_q     <= cfg_iw;
      ih_q     <= cfg_ih;
      bypass_q <= cfg_bypass;
      border_q <= cfg_border;
    end
  end

  // Free-running delay line matching the core latency.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i] <= 1'b0;
        sof_p[i] <= 1'b0;
        eol_p[i] <= 1'b0;
        brd_p[i] <= 1'b0;
        pix_p[i] <= '0;
      end
    end else begin
      vld_p[0] <= issue;
      sof_p[0] <= issue & tag_sof;
      eol_p[0] <= issue & last_pix;
      brd_p[0] <= border;
      pix_p[0] <= mid_pix;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        sof_p[i] <= sof_p[i-1];
        eol_p[i] <= eol_p[i-1];
        brd_p[i] <= brd_p[i-1];
        pix_p[i] <= pix_p[i-1];
      end
    end
  end

  // Output select: middle pixel, forced zero, or core result.
  always_comb begin
    out_val = vld_p[LAT-1];
    out_sof = vld_p[LAT-1] & sof_p[LAT-1];
    out_eol = vld_p[LAT-1] & eol_p[LAT-1];
    out_dat = '0;
    if (vld_p[LAT-1]) begin
      if (bypass_q || (brd_p[LAT-1] && !border_q))
        out_dat = pix_p[LAT-1];
      else if (brd_p[LAT-1])
        out_dat = '0;
      else
        out_dat = core_dout;
    end
  end

  // Sticky flag: the core missed a result we were about to use.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      err_sync <= 1'b0;
    else if (vld_p[LAT-1] && !brd_p[LAT-1] && !bypass_q && !core_dout_val)
      err_sync <= 1'b1;
  end

endmodule

// File: tb/tb_median_filter_sched_mc.sv
// Scoreboard bench for median_filter_sched_mc: a line-stack model and a
// fixed-latency core model drive the DUT; expected outputs are queued per
// frame and a negedge monitor checks them in order.
module tb_median_filter_sched_mc;

  localparam int SIZE  = 3;
  localparam int NCH   = 2;
  localparam int DW    = 14;
  localparam int DW_MD = 16;
  localparam int LAT   = 4;
  localparam int HALF  = SIZE / 2;
  localparam int PW    = NCH * DW;

  logic                       clk, rstb;
  logic [DW_MD-1:0]           cfg_iw, cfg_ih;
  logic                       cfg_bypass, cfg_border, frm_abort;
  logic [SIZE*NCH*(DW+1)-1:0] line_stack_dout;
  logic                       line_stack_rd_en;
  logic [15:0]                rcvd_line_cntr, sent_line_cntr;
  logic [SIZE*NCH*DW-1:0]     core_din;
  logic [PW-1:0]              core_dout;
  logic                       core_dout_val;
  logic [PW-1:0]              out_dat;
  logic                       out_val, out_sof, out_eol, out_rdy, err_sync;

  median_filter_sched_mc #(.SIZE(SIZE), .NCH(NCH), .DW_VD(DW), .DW_MD(DW_MD), .LAT(LAT)) dut (
    .clk(clk), .rstb(rstb), .cfg_iw(cfg_iw), .cfg_ih(cfg_ih),
    .cfg_bypass(cfg_bypass), .cfg_border(cfg_border), .frm_abort(frm_abort),
    .line_stack_dout(line_stack_dout), .line_stack_rd_en(line_stack_rd_en),
    .rcvd_line_cntr(rcvd_line_cntr), .sent_line_cntr(sent_line_cntr),
    .core_din(core_din), .core_dout(core_dout), .core_dout_val(core_dout_val),
    .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eol(out_eol),
    .out_rdy(out_rdy), .err_sync(err_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] dat;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   n_cmp = 0, n_bad = 0, out_cnt = 0, cyc = 0;
  int   first_val_cyc = -1, first_send_cyc = -1;
  int   pop_cnt = 0;
  int   tb_iw = 8, tb_ih = 6;
  bit   tb_bypass = 0, tb_border = 0;
  bit   frame_clr = 0;
  bit   mask_en = 0, kill_en = 0, kill_all = 0;
  int   mask_row = 0, mask_pix = 0, kill_pop = 0;
  int   fl_row, fl_pix;

  // Pixel code: {row, col, stack line, channel, 1}.
  function automatic logic [DW-1:0] enc(input int r, input int p, input int l, input int c);
    return DW'(((r & 15) << 10) | ((p & 15) << 6) | ((l & 3) << 4) | ((c & 3) << 2) | 1);
  endfunction

  // Line stack model: position follows the pops seen in this frame.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_clr)
      pop_cnt <= 0;
    else if (line_stack_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (first_send_cyc < 0 && pop_cnt == HALF * tb_iw)
        first_send_cyc <= cyc;
    end
  end

  always_comb begin
    fl_row = pop_cnt / tb_iw - HALF;
    fl_pix = pop_cnt % tb_iw;
    line_stack_dout = '0;
    for (int l = 0; l < SIZE; l++)
      for (int c = 0; c < NCH; c++)
        line_stack_dout[(l*NCH+c)*(DW+1) +: DW+1] =
          {!(mask_en && l == HALF && fl_row == mask_row && fl_pix == mask_pix),
           enc(fl_row, fl_pix, l, c)};
  end

  // Core model: per-channel sum of the stack column, LAT cycles later.
  logic [PW-1:0] core_sum;
  logic [PW-1:0] cq [LAT];
  logic          cv [LAT];
  always_comb begin
    core_sum = '0;
    for (int c = 0; c < NCH; c++)
      for (int l = 0; l < SIZE; l++)
        core_sum[c*DW +: DW] = core_sum[c*DW +: DW] + core_din[(l*NCH+c)*DW +: DW];
  end
  always @(posedge clk) begin
    cq[0] <= core_sum;
    cv[0] <= line_stack_rd_en && !kill_all && !(kill_en && pop_cnt == kill_pop);
    for (int i = 1; i < LAT; i++) begin
      cq[i] <= cq[i-1];
      cv[i] <= cv[i-1];
    end
  end
  assign core_dout     = cq[LAT-1];
  assign core_dout_val = cv[LAT-1];

  // Monitor: every out_val pops one expected entry.
  always @(negedge clk) begin
    if (out_val) begin
      out_cnt = out_cnt + 1;
      if (first_val_cyc < 0) first_val_cyc = cyc;
      n_cmp = n_cmp + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL unexpected_out: out_val=1 dat=%h with nothing expected", out_dat);
      end else begin
        got_e = exp_q.pop_front();
        if ({out_dat, out_sof, out_eol} !== got_e) begin
          n_bad = n_bad + 1;
          $display("FAIL out_%0d: got dat=%h sof=%b eol=%b, expected dat=%h sof=%b eol=%b",
                   out_cnt, out_dat, out_sof, out_eol, got_e.dat, got_e.sof, got_e.eol);
        end
      end
    end
  end

  function automatic exp_t expect_at(input int r, input int p);
    exp_t e;
    logic brd;
    logic [DW-1:0] mid, core;
    brd = (r < HALF) || (r >= tb_ih - HALF) || (p < HALF) || (p >= tb_iw - HALF) ||
          (mask_en && r == mask_row && p == mask_pix);
    e.dat = '0;
    for (int c = 0; c < NCH; c++) begin
      mid  = enc(r, p, HALF, c);
      core = '0;
      for (int l = 0; l < SIZE; l++) core = core + enc(r, p, l, c);
      if (tb_bypass || (brd && !tb_border)) e.dat[c*DW +: DW] = mid;
      else if (brd)                         e.dat[c*DW +: DW] = '0;
      else                                  e.dat[c*DW +: DW] = core;
    end
    e.sof = (r == 0) && (p == 0);
    e.eol = (p == tb_iw - 1);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_outs(input int n, input int budget, input string name);
    int k = 0;
    while (out_cnt < n && k < budget) begin tick(); k++; end
    check(name, out_cnt, n);
  endtask

  task automatic wait_pop(input int n, input int budget, input string name);
    int k = 0;
    while (pop_cnt < n && k < budget) begin tick(); k++; end
    check(name, pop_cnt, n);
  endtask

  // Push expected outputs for rows 0..last_row-1 plus cols 0..last_pix of last_row.
  task automatic push_frame(input int last_row, input int last_pix);
    for (int r = 0; r <= last_row; r++)
      for (int p = 0; p < tb_iw; p++)
        if (r < last_row || p <= last_pix) exp_q.push_back(expect_at(r, p));
  endtask

  task automatic start_frame(input int iw, input int ih, input bit byp, input bit brd);
    tb_iw = iw; tb_ih = ih; tb_bypass = byp; tb_border = brd;
    cfg_iw = DW_MD'(iw); cfg_ih = DW_MD'(ih); cfg_bypass = byp; cfg_border = brd;
    frame_clr = 1;
    tick();
    frame_clr = 0;
    out_cnt = 0;
    tick();
  endtask

  task automatic end_frame(input string name);
    rcvd_line_cntr = 16'd0;
    repeat (3) tick();
    check({name, "_sent_clr"}, sent_line_cntr, 0);
    check({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  int out_snap;

  initial begin
    rstb = 0; cfg_iw = 16'd8; cfg_ih = 16'd6; cfg_bypass = 0; cfg_border = 0;
    frm_abort = 0; rcvd_line_cntr = 0; out_rdy = 1;
    repeat (3) tick();
    check("rst_out_val", out_val, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_out_dat", out_dat, 0);
    check("rst_err_sync", err_sync, 0);
    check("rst_sent", sent_line_cntr, 0);
    check("rst_rd_en", line_stack_rd_en, 0);
    rstb = 1;
    repeat (3) tick();
    check("idle_rd_en", line_stack_rd_en, 0);

    // Plain frame; a mid-frame cfg change must be ignored.
    start_frame(8, 6, 0, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_pop(2, 50, "f1_fill_start");
    cfg_iw = 16'd5; cfg_ih = 16'd4; cfg_border = 1;
    wait_outs(48, 800, "f1_outs");
    check("f1_latency", first_val_cyc - first_send_cyc, LAT);
    check("f1_pops", pop_cnt, 56);
    check("f1_sent_in_fend", sent_line_cntr, 6);
    end_frame("f1");

    // Border zeroing plus one masked interior pixel.
    mask_en = 1; mask_row = 2; mask_pix = 3;
    start_frame(8, 6, 0, 1);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_outs(48, 800, "f2_outs");
    end_frame("f2");
    mask_en = 0;

    // Back-pressure at line 2 pixel 3.
    start_frame(8, 6, 0, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_pop(8 + 2*8 + 3, 400, "f3_reach_stall");
    out_rdy = 0;
    repeat (5) tick();
    check("f3_no_pop_stalled", pop_cnt, 8 + 2*8 + 3);
    out_rdy = 1;
    wait_outs(48, 800, "f3_outs");
    end_frame("f3");

    // Line arrival throttling.
    start_frame(8, 6, 0, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd2;
    wait_outs(8, 200, "f4_line0");
    repeat (30) tick();
    check("f4_hold_pops", pop_cnt, 16);
    check("f4_hold_outs", out_cnt, 8);
    rcvd_line_cntr = 16'd3;
    wait_outs(16, 200, "f4_line1");
    repeat (30) tick();
    check("f4_hold2_pops", pop_cnt, 24);
    rcvd_line_cntr = 16'd6;
    wait_outs(48, 800, "f4_outs");
    end_frame("f4");

    // Abort at line 3 pixel 5.
    start_frame(8, 6, 0, 0);
    push_frame(3, 5);
    rcvd_line_cntr = 16'd6;
    wait_pop(8 + 3*8 + 5, 400, "f5_reach_abort");
    frm_abort = 1;
    tick();
    frm_abort = 0;
    wait_outs(30, 100, "f5_drain");
    repeat (20) tick();
    check("f5_silence", out_cnt, 30);
    check("f5_pops", pop_cnt, 38);
    repeat (10) tick();
    check("f5_fend_hold", pop_cnt, 38);
    end_frame("f5");

    // Next frame after abort, smaller image.
    start_frame(5, 4, 0, 0);
    push_frame(3, 4);
    rcvd_line_cntr = 16'd4;
    wait_outs(20, 400, "f6_outs");
    end_frame("f6");

    // Missing core result on interior pixel (2,3).
    kill_en = 1; kill_pop = 8 + 2*8 + 3;
    start_frame(8, 6, 0, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_outs(16, 400, "f7_rows01");
    check("f7_err_before", err_sync, 0);
    wait_outs(48, 800, "f7_outs");
    check("f7_err_set", err_sync, 1);
    end_frame("f7");
    kill_en = 0;
    repeat (5) tick();
    check("f7_err_sticky", err_sync, 1);

    // Reset mid-frame drops in-flight entries.
    start_frame(8, 6, 0, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_pop(8 + 8 + 4, 400, "f8_reach_reset");
    rstb = 0;
    exp_q.delete();
    rcvd_line_cntr = 16'd0;
    out_snap = out_cnt;
    tick();
    check("f8_rst_out_val", out_val, 0);
    check("f8_rst_err_clr", err_sync, 0);
    check("f8_rst_sent", sent_line_cntr, 0);
    tick();
    rstb = 1;
    repeat (20) tick();
    check("f8_no_out_after_rst", out_cnt, out_snap);

    // Bypass with no valid core results must never flag an error.
    kill_all = 1;
    start_frame(8, 6, 1, 0);
    push_frame(5, 7);
    rcvd_line_cntr = 16'd6;
    wait_outs(48, 800, "f9_outs");
    check("f9_bypass_no_err", err_sync, 0);
    end_frame("f9");
    kill_all = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
